// File: rtl/stage_mem_if.sv
// Bundle of the execute-stage inputs, write-back outputs and data-memory
// handshake for stage_mem; the slave modport is the stage, master drives it.
interface stage_mem_if;
   logic [2:0]  cs_memop;
   logic        begin_valid;
   logic [31:0] begin_inst;
   logic [31:0] begin_newpc;
   logic [31:0] begin_aluoutput;
   logic [31:0] begin_regdatab;
   logic        stall;
   logic        end_valid;
   logic [31:0] end_inst;
   logic [31:0] end_newpc;
   logic [31:0] end_aluoutput;
   logic [31:0] end_memdata;
   logic        end_misalign;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport slave (
      input  cs_memop, begin_valid, begin_inst, begin_newpc, begin_aluoutput, begin_regdatab,
      input  dmem_ack, dmem_rdata,
      output stall, end_valid, end_inst, end_newpc, end_aluoutput, end_memdata, end_misalign,
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
   );

   modport master (
      output cs_memop, begin_valid, begin_inst, begin_newpc, begin_aluoutput, begin_regdatab,
      output dmem_ack, dmem_rdata,
      input  stall, end_valid, end_inst, end_newpc, end_aluoutput, end_memdata, end_misalign,
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
   );
endinterface

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack handshake and
// stalls upstream while busy. Optional macro STAGE_MEM_ALIGN_CHECK_EN flags misaligned LW/SW.
module stage_mem (
   input logic        clk,
   input logic        rst_n,
   stage_mem_if.slave bus_io
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [2:0] OP_LW  = 3'd1;
   localparam logic [2:0] OP_SW  = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;

   function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] rdata);
      logic [31:0] sh;
      logic [7:0]  b;
      sh = rdata >> {off, 3'b000};
      b  = sh[7:0];
      case (op)
         OP_LW:   fmt_load = rdata;
         OP_LB:   fmt_load = {{24{b[7]}}, b};
         OP_LBU:  fmt_load = {24'd0, b};
         default: fmt_load = 32'd0;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] off);
      store_be = (op == OP_SB) ? (4'b0001 << off) : 4'b1111;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] op, input logic [31:0] d);
      case (op)
         OP_SW:   store_wdata = d;
         OP_SB:   store_wdata = {4{d[7:0]}};
         default: store_wdata = 32'd0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] inst_q, inst_d, newpc_q, newpc_d, alu_q, alu_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        ev_q, ev_d, emis_q, emis_d;
   logic [31:0] einst_q, einst_d, enewpc_q, enewpc_d, ealu_q, ealu_d, emem_q, emem_d;

   logic accept, is_load, is_store, misalign;

   assign accept   = bus_io.begin_valid && (state_q == IDLE);
   assign is_load  = (bus_io.cs_memop == OP_LW) || (bus_io.cs_memop == OP_LB) ||
                     (bus_io.cs_memop == OP_LBU);
   assign is_store = (bus_io.cs_memop == OP_SW) || (bus_io.cs_memop == OP_SB);
`ifdef STAGE_MEM_ALIGN_CHECK_EN
   assign misalign = ((bus_io.cs_memop == OP_LW) || (bus_io.cs_memop == OP_SW)) &&
                     (bus_io.begin_aluoutput[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      off_d    = off_q;
      inst_d   = inst_q;
      newpc_d  = newpc_q;
      alu_d    = alu_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      ev_d     = 1'b0;
      emis_d   = emis_q;
      einst_d  = einst_q;
      enewpc_d = enewpc_q;
      ealu_d   = ealu_q;
      emem_d   = emem_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = bus_io.cs_memop;
               off_d   = bus_io.begin_aluoutput[1:0];
               inst_d  = bus_io.begin_inst;
               newpc_d = bus_io.begin_newpc;
               alu_d   = bus_io.begin_aluoutput;
               if ((is_load || is_store) && !misalign) begin
                  req_d   = 1'b1;
                  we_d    = is_store;
                  addr_d  = {bus_io.begin_aluoutput[31:2], 2'b00};
                  be_d    = store_be(bus_io.cs_memop, bus_io.begin_aluoutput[1:0]);
                  wdata_d = store_wdata(bus_io.cs_memop, bus_io.begin_regdatab);
                  state_d = BUSY;
               end else begin
                  // Non-memory ops and rejected misaligned accesses retire directly.
                  ev_d     = 1'b1;
                  einst_d  = bus_io.begin_inst;
                  enewpc_d = bus_io.begin_newpc;
                  ealu_d   = bus_io.begin_aluoutput;
                  emem_d   = 32'd0;
                  emis_d   = misalign;
               end
            end
         end
         BUSY: begin
            if (bus_io.dmem_ack) begin
               req_d    = 1'b0;
               state_d  = IDLE;
               ev_d     = 1'b1;
               einst_d  = inst_q;
               enewpc_d = newpc_q;
               ealu_d   = alu_q;
               emem_d   = fmt_load(op_q, off_q, bus_io.dmem_rdata);
               emis_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= 3'd0;
         off_q    <= 2'd0;
         inst_q   <= 32'd0;
         newpc_q  <= 32'd0;
         alu_q    <= 32'd0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         be_q     <= 4'd0;
         wdata_q  <= 32'd0;
         ev_q     <= 1'b0;
         emis_q   <= 1'b0;
         einst_q  <= 32'd0;
         enewpc_q <= 32'd0;
         ealu_q   <= 32'd0;
         emem_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         off_q    <= off_d;
         inst_q   <= inst_d;
         newpc_q  <= newpc_d;
         alu_q    <= alu_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         ev_q     <= ev_d;
         emis_q   <= emis_d;
         einst_q  <= einst_d;
         enewpc_q <= enewpc_d;
         ealu_q   <= ealu_d;
         emem_q   <= emem_d;
      end
   end

   // stall decodes the state register only, so there is no input-to-stall path.
   assign bus_io.stall         = (state_q == BUSY);
   assign bus_io.end_valid     = ev_q;
   assign bus_io.end_inst      = einst_q;
   assign bus_io.end_newpc     = enewpc_q;
   assign bus_io.end_aluoutput = ealu_q;
   assign bus_io.end_memdata   = emem_q;
   assign bus_io.end_misalign  = emis_q;
   assign bus_io.dmem_req      = req_q;
   assign bus_io.dmem_we       = we_q;
   assign bus_io.dmem_addr     = addr_q;
   assign bus_io.dmem_be       = be_q;
   assign bus_io.dmem_wdata    = wdata_q;
endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: reset, NOP, SW, LB/LBU back-to-back, SB,
// reset mid-transaction and the LW misalignment case.
module tb_stage_mem;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   stage_mem_if u_if ();

   stage_mem dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] rb);
      u_if.begin_valid     = 1'b1;
      u_if.cs_memop        = op;
      u_if.begin_aluoutput = alu;
      u_if.begin_regdatab  = rb;
      u_if.begin_inst      = 32'h1000_0000 | alu;
      u_if.begin_newpc     = alu + 32'd4;
      tick();
      u_if.begin_valid = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      u_if.cs_memop        = 3'd0;
      u_if.begin_valid     = 1'b0;
      u_if.begin_inst      = 32'd0;
      u_if.begin_newpc     = 32'd0;
      u_if.begin_aluoutput = 32'd0;
      u_if.begin_regdatab  = 32'd0;
      u_if.dmem_ack        = 1'b0;
      u_if.dmem_rdata      = 32'd0;
      tick();
      tick();
      chk("rst_stall", u_if.stall, 0);
      chk("rst_end_valid", u_if.end_valid, 0);
      chk("rst_req", u_if.dmem_req, 0);
      chk("rst_be", u_if.dmem_be, 0);
      chk("rst_misalign", u_if.end_misalign, 0);
      chk("rst_alu", u_if.end_aluoutput, 0);
      rst_n = 1'b1;
      tick();

      // Non-memory op
      u_if.begin_valid     = 1'b1;
      u_if.cs_memop        = 3'd0;
      u_if.begin_inst      = 32'h0022_1820;
      u_if.begin_newpc     = 32'h0000_0008;
      u_if.begin_aluoutput = 32'h0000_1234;
      tick();
      u_if.begin_valid = 1'b0;
      chk("nop_valid", u_if.end_valid, 1);
      chk("nop_inst", u_if.end_inst, 32'h0022_1820);
      chk("nop_newpc", u_if.end_newpc, 32'h0000_0008);
      chk("nop_alu", u_if.end_aluoutput, 32'h0000_1234);
      chk("nop_memdata", u_if.end_memdata, 0);
      chk("nop_req", u_if.dmem_req, 0);
      chk("nop_stall", u_if.stall, 0);
      tick();
      chk("nop_valid_pulse", u_if.end_valid, 0);
      chk("nop_alu_hold", u_if.end_aluoutput, 32'h0000_1234);
      chk("nop_req_after", u_if.dmem_req, 0);

      // Code 7 is treated as none
      issue(3'd7, 32'h0000_0044, 32'd0);
      chk("op7_valid", u_if.end_valid, 1);
      chk("op7_req", u_if.dmem_req, 0);
      chk("op7_alu", u_if.end_aluoutput, 32'h0000_0044);

      // SW, ack after 3 cycles of stall
      issue(3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
      chk("sw_req", u_if.dmem_req, 1);
      chk("sw_we", u_if.dmem_we, 1);
      chk("sw_addr", u_if.dmem_addr, 32'h0000_0100);
      chk("sw_be", u_if.dmem_be, 4'b1111);
      chk("sw_wdata", u_if.dmem_wdata, 32'hDEAD_BEEF);
      chk("sw_stall1", u_if.stall, 1);
      chk("sw_ev1", u_if.end_valid, 0);
      u_if.begin_valid = 1'b1;
      u_if.cs_memop    = 3'd0;
      tick();
      chk("sw_stall2", u_if.stall, 1);
      chk("sw_req2", u_if.dmem_req, 1);
      chk("sw_ev2", u_if.end_valid, 0);
      u_if.begin_valid = 1'b0;
      tick();
      chk("sw_stall3", u_if.stall, 1);
      chk("sw_addr3", u_if.dmem_addr, 32'h0000_0100);
      u_if.dmem_ack = 1'b1;
      tick();
      u_if.dmem_ack = 1'b0;
      chk("sw_done_valid", u_if.end_valid, 1);
      chk("sw_done_req", u_if.dmem_req, 0);
      chk("sw_done_stall", u_if.stall, 0);
      chk("sw_done_memdata", u_if.end_memdata, 0);
      chk("sw_done_alu", u_if.end_aluoutput, 32'h0000_0100);
      chk("sw_done_inst", u_if.end_inst, 32'h1000_0100);

      // LB then LBU back-to-back at 0x103
      issue(3'd3, 32'h0000_0103, 32'd0);
      chk("lb_req", u_if.dmem_req, 1);
      chk("lb_we", u_if.dmem_we, 0);
      chk("lb_addr", u_if.dmem_addr, 32'h0000_0100);
      chk("lb_be", u_if.dmem_be, 4'b1111);
      u_if.dmem_ack   = 1'b1;
      u_if.dmem_rdata = 32'h80FF_1122;
      tick();
      u_if.dmem_ack = 1'b0;
      chk("lb_valid", u_if.end_valid, 1);
      chk("lb_memdata", u_if.end_memdata, 32'hFFFF_FF80);
      issue(3'd4, 32'h0000_0103, 32'd0);
      chk("lbu_ev_no_repeat", u_if.end_valid, 0);
      chk("lbu_req", u_if.dmem_req, 1);
      chk("lbu_stall", u_if.stall, 1);
      u_if.dmem_ack = 1'b1;
      tick();
      u_if.dmem_ack = 1'b0;
      chk("lbu_valid", u_if.end_valid, 1);
      chk("lbu_memdata", u_if.end_memdata, 32'h0000_0080);

      // SB with minimum latency
      issue(3'd5, 32'h0000_0202, 32'h0000_00AB);
      chk("sb_addr", u_if.dmem_addr, 32'h0000_0200);
      chk("sb_be", u_if.dmem_be, 4'b0100);
      chk("sb_wdata", u_if.dmem_wdata, 32'hABAB_ABAB);
      chk("sb_we", u_if.dmem_we, 1);
      u_if.dmem_ack = 1'b1;
      tick();
      u_if.dmem_ack = 1'b0;
      chk("sb_valid", u_if.end_valid, 1);
      chk("sb_memdata", u_if.end_memdata, 0);
      chk("sb_req_low", u_if.dmem_req, 0);

      // Reset mid-transaction
      issue(3'd1, 32'h0000_0300, 32'd0);
      chk("rstmid_req_before", u_if.dmem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_req_async", u_if.dmem_req, 0);
      chk("rstmid_stall_async", u_if.stall, 0);
      u_if.dmem_ack = 1'b1;
      tick();
      chk("rstmid_ev_in_rst", u_if.end_valid, 0);
      rst_n = 1'b1;
      tick();
      u_if.dmem_ack = 1'b0;
      chk("rstmid_ack_ignored_ev", u_if.end_valid, 0);
      chk("rstmid_ack_ignored_req", u_if.dmem_req, 0);
      issue(3'd1, 32'h0000_0104, 32'd0);
      chk("post_rst_req", u_if.dmem_req, 1);
      chk("post_rst_addr", u_if.dmem_addr, 32'h0000_0104);
      u_if.dmem_ack   = 1'b1;
      u_if.dmem_rdata = 32'h1234_5678;
      tick();
      u_if.dmem_ack = 1'b0;
      chk("post_rst_valid", u_if.end_valid, 1);
      chk("post_rst_memdata", u_if.end_memdata, 32'h1234_5678);

      // LW at misaligned address 0x102
      issue(3'd1, 32'h0000_0102, 32'd0);
`ifdef STAGE_MEM_ALIGN_CHECK_EN
      chk("mis_req", u_if.dmem_req, 0);
      chk("mis_valid", u_if.end_valid, 1);
      chk("mis_flag", u_if.end_misalign, 1);
      chk("mis_memdata", u_if.end_memdata, 0);
      chk("mis_stall", u_if.stall, 0);
`else
      chk("unal_req", u_if.dmem_req, 1);
      chk("unal_addr", u_if.dmem_addr, 32'h0000_0100);
      u_if.dmem_ack   = 1'b1;
      u_if.dmem_rdata = 32'hCAFE_F00D;
      tick();
      u_if.dmem_ack = 1'b0;
      chk("unal_valid", u_if.end_valid, 1);
      chk("unal_memdata", u_if.end_memdata, 32'hCAFE_F00D);
      chk("unal_flag", u_if.end_misalign, 0);
`endif
      tick();
      chk("final_ev_low", u_if.end_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
